mas_seq_ctrl: RTL and testbench



---
 rtl/mas_seq_ctrl_if.sv | 42 ++++
 rtl/mas_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_mas_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mas_seq_ctrl_if.sv
// Operand stream, MAS datapath bus and result stream of the MAS sequencer.
// The controller uses the master view; the operand source, MAS unit and
// result consumer together form the slave view.
interface mas_seq_ctrl_if;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic signed [4:0] in_din;
  logic              in_last;

  logic signed [4:0] mas_din1;
  logic signed [4:0] mas_din2;
  logic [1:0]        mas_sel;
  logic signed [4:0] mas_q;
  logic signed [4:0] mas_tdout;
  logic [1:0]        mas_tcmp;
  logic signed [3:0] mas_dout;

  logic              out_valid;
  logic              out_ready;
  logic signed [4:0] out_data;
  logic [1:0]        out_tcmp;
  logic              out_err;

  modport master (
    input  in_valid, in_sel, in_din, in_last,
    output in_ready,
    output mas_din1, mas_din2, mas_sel, mas_q,
    input  mas_tdout, mas_tcmp, mas_dout,
    output out_valid, out_data, out_tcmp, out_err,
    input  out_ready
  );

  modport slave (
    output in_valid, in_sel, in_din, in_last,
    input  in_ready,
    input  mas_din1, mas_din2, mas_sel, mas_q,
    output mas_tdout, mas_tcmp, mas_dout,
    input  out_valid, out_data, out_tcmp, out_err,
    output out_ready
  );
endinterface

// File: rtl/mas_seq_ctrl.sv
// Sequencer that chains an operand stream through one external MAS unit,
// feeding each reduced result back as the next Din1.
//
// state | meaning
// IDLE  | waiting for the first word of a chain; Q may be reloaded
// RUN   | waiting for the next chained word
// EXEC  | MAS unit evaluating the registered operands; result sampled
// DONE  | result presented until the consumer takes it
module mas_seq_ctrl #(
  parameter int unsigned       MAX_OPS = 8,
  parameter logic signed [4:0] Q_RST   = 5'sd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_load,
  input  logic signed [4:0] q_cfg,
  output logic [3:0]        op_cnt,
  mas_seq_ctrl_if.master    bus
);

  typedef enum logic [1:0] {IDLE, RUN, EXEC, DONE} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OPS);

  state_t            state, state_nxt;
  logic signed [4:0] acc;
  logic signed [4:0] q_reg;
  logic signed [4:0] din1_r, din2_r;
  logic [1:0]        sel_r;
  logic [1:0]        tcmp_r;
  logic              term, err;
  logic              accept;
  logic [3:0]        cnt_inc;
  logic              hit_max;
  logic              tdout_unused;

  // in_ready is also held low while reset is asserted so every output reads 0
  assign bus.in_ready  = rst_n && ((state == IDLE) || (state == RUN));
  assign accept        = bus.in_valid && bus.in_ready;
  assign cnt_inc       = op_cnt + 4'd1;
  assign hit_max       = (cnt_inc == MAX_CNT);

  assign bus.mas_din1  = din1_r;
  assign bus.mas_din2  = din2_r;
  assign bus.mas_sel   = sel_r;
  assign bus.mas_q     = q_reg;
  assign bus.out_tcmp  = tcmp_r;
  // the pre-reduction value is observed by the consumer only
  assign tdout_unused  = ^bus.mas_tdout;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and result presentation
  always_comb begin
    state_nxt     = state;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_err   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = bus.in_last ? DONE : RUN;
      RUN:  if (accept) state_nxt = EXEC;
      EXEC: state_nxt = term ? DONE : RUN;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc;
        bus.out_err   = err;
        if (bus.out_ready) state_nxt = IDLE;
      end
    endcase
  end

  // accumulator, Q register, MAS operand registers and chain bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      q_reg  <= Q_RST;
      din1_r <= '0;
      din2_r <= '0;
      sel_r  <= '0;
      tcmp_r <= '0;
      op_cnt <= '0;
      term   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // a same-cycle word still reaches its MAS step after this update
          if (q_load) q_reg <= q_cfg;
          if (accept) begin
            acc    <= bus.in_din;
            op_cnt <= 4'd1;
            tcmp_r <= 2'b00;
          end
        end
        RUN: begin
          if (accept) begin
            din1_r <= acc;
            din2_r <= bus.in_din;
            sel_r  <= bus.in_sel;
            op_cnt <= cnt_inc;
            term   <= bus.in_last || hit_max;
            err    <= hit_max && !bus.in_last;
          end
        end
        EXEC: begin
          acc    <= {bus.mas_dout[3], bus.mas_dout};
          tcmp_r <= bus.mas_tcmp;
        end
        DONE: begin
          if (bus.out_ready) begin
            op_cnt <= '0;
            err    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mas_seq_ctrl.sv
// Scoreboard bench for mas_seq_ctrl: a driver issues directed and random
// operand chains, a chain-level model queues the expected results, and a
// monitor compares whatever the controller presents against the queue head.
module tb_mas_seq_ctrl;
  localparam int MAX_OPS = 8;

  typedef struct {int din; int sel; bit last;} word_t;
  typedef struct {int data; int tcmp; int err; int cnt;} exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              q_load = 1'b0;
  logic signed [4:0] q_cfg = '0;
  logic [3:0]        op_cnt;

  mas_seq_ctrl_if bus();

  mas_seq_ctrl #(.MAX_OPS(MAX_OPS), .Q_RST(5'sd7)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .q_load (q_load),
    .q_cfg  (q_cfg),
    .op_cnt (op_cnt),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];
  word_t cur_chain[$];
  int    cur_q = 7;
  bit    auto_exp = 1'b0;
  bit    rdy_force = 1'b0;
  bit    rdy_val = 1'b0;

  function automatic int wrap(int x, int bits);
    int m, v;
    m = 1 << bits;
    v = x & (m - 1);
    if (v >= m / 2) v -= m;
    return v;
  endfunction

  // external MAS unit behaviour: {temp[4:0], tcmp[1:0], dout[3:0]}
  function automatic logic [10:0] mas_fn(int d1, int d2, logic [1:0] sel, int q);
    int t, r;
    logic ge0, geq;
    case (sel)
      2'b00:   t = d1 + d2;
      2'b11:   t = d1 - d2;
      default: t = d1;
    endcase
    t   = wrap(t, 5);
    ge0 = (t >= 0);
    geq = (t >= q);
    if (ge0 && geq)        r = t - q;
    else if (!ge0 && !geq) r = t + q;
    else                   r = t;
    return {5'(t), geq, ge0, 4'(r)};
  endfunction

  // fold a whole chain with the Q in force when it started
  function automatic exp_t model_chain(word_t w[$], int q);
    exp_t e;
    int acc, tc;
    logic [10:0] m;
    acc = w[0].din;
    tc  = 0;
    for (int i = 1; i < w.size(); i++) begin
      m   = mas_fn(acc, w[i].din, 2'(w[i].sel), q);
      acc = wrap(int'(m[3:0]), 4);
      tc  = int'(m[5:4]);
    end
    e.data = acc;
    e.tcmp = tc;
    e.err  = (w.size() == MAX_OPS && !w[w.size()-1].last) ? 1 : 0;
    e.cnt  = w.size();
    return e;
  endfunction

  logic [10:0] mas_res;
  assign mas_res = mas_fn(int'(bus.mas_din1), int'(bus.mas_din2), bus.mas_sel, int'(bus.mas_q));
  assign bus.mas_tdout = mas_res[10:6];
  assign bus.mas_tcmp  = mas_res[5:4];
  assign bus.mas_dout  = mas_res[3:0];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  int'(bus.in_ready), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_data"},  int'(bus.out_data), 0);
    chk({tag, "_out_tcmp"},  int'(bus.out_tcmp), 0);
    chk({tag, "_out_err"},   int'(bus.out_err), 0);
    chk({tag, "_op_cnt"},    int'(op_cnt), 0);
    chk({tag, "_din1"},      int'(bus.mas_din1), 0);
    chk({tag, "_din2"},      int'(bus.mas_din2), 0);
    chk({tag, "_sel"},       int'(bus.mas_sel), 0);
    chk({tag, "_mas_q"},     int'(bus.mas_q), 7);
  endtask

  task automatic send_word(input int din, input int sel, input bit last,
                           input bit ld, input int qv);
    word_t w;
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_din   = 5'(din);
    bus.in_sel   = 2'(sel);
    bus.in_last  = last;
    q_load       = ld;
    q_cfg        = 5'(qv);
    n = 0;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("send_wait_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    q_load       = 1'b0;
    if (ld) cur_q = wrap(qv, 5);
    w.din  = wrap(din, 5);
    w.sel  = sel & 3;
    w.last = last;
    cur_chain.push_back(w);
    if (last || cur_chain.size() == MAX_OPS) begin
      if (auto_exp) sb.push_back(model_chain(cur_chain, cur_q));
      cur_chain.delete();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // consumer: random or forced acceptance, changed well away from clock edges
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: every presented result must match the queue head until taken
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: out_data %0d presented, no result expected",
                 int'(bus.out_data));
      end else begin
        chk("out_data", int'(bus.out_data), sb[0].data);
        chk("out_tcmp", int'(bus.out_tcmp), sb[0].tcmp);
        chk("out_err",  int'(bus.out_err),  sb[0].err);
        chk("op_cnt",   int'(op_cnt),       sb[0].cnt);
        chk("done_in_ready", int'(bus.in_ready), 0);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int n, len, qv;
    bit ld;
    bus.in_valid = 1'b0;
    bus.in_sel   = '0;
    bus.in_din   = '0;
    bus.in_last  = 1'b0;

    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // two chained steps, second one wraps past Q; result 2 arrives 2 cycles late
    sb.push_back('{data: 2, tcmp: 3, err: 0, cnt: 3});
    send_word(3, 0, 0, 0, 0);
    send_word(2, 0, 0, 0, 0);
    send_word(4, 0, 1, 0, 0);
    @(negedge clk);
    chk("lat_exec_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_done_valid", int'(bus.out_valid), 1);

    // subtraction going negative gets Q added back
    sb.push_back('{data: 5, tcmp: 0, err: 0, cnt: 2});
    send_word(1, 0, 0, 0, 0);
    send_word(3, 3, 1, 0, 0);

    // single-word chain: no MAS step, result one cycle after accept
    sb.push_back('{data: -6, tcmp: 0, err: 0, cnt: 1});
    send_word(-6, 2, 1, 0, 0);
    @(negedge clk);
    chk("single_valid", int'(bus.out_valid), 1);

    // truncation at MAX_OPS; the overflow words open a new chain
    sb.push_back('{data: 1, tcmp: 1, err: 1, cnt: 8});
    sb.push_back('{data: 3, tcmp: 1, err: 0, cnt: 3});
    for (int i = 0; i < 10; i++) send_word(1, 1, 0, 0, 0);
    send_word(2, 0, 1, 0, 0);
    wait_drain();

    // result held with consumer stalled; q_load in DONE is dropped
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    sb.push_back('{data: 5, tcmp: 0, err: 0, cnt: 2});
    send_word(1, 0, 0, 0, 0);
    send_word(3, 3, 1, 0, 0);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_done", int'(bus.out_valid), 1);
    q_load = 1'b1;
    q_cfg  = 5'sd3;
    @(posedge clk);
    #1;
    q_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_mas_q", int'(bus.mas_q), 7);
    end
    rdy_force = 1'b0;
    wait_drain();
    @(negedge clk);
    q_load = 1'b1;
    q_cfg  = 5'sd3;
    @(posedge clk);
    #1;
    q_load = 1'b0;
    chk("idle_qload", int'(bus.mas_q), 3);
    cur_q = 3;

    // reset during EXEC discards the chain and restores Q_RST
    send_word(5, 0, 0, 0, 0);
    send_word(1, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    cur_chain.delete();
    cur_q = 7;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{data: 3, tcmp: 1, err: 0, cnt: 2});
    send_word(2, 0, 0, 0, 0);
    send_word(1, 0, 1, 0, 0);
    wait_drain();

    // random chains, some longer than MAX_OPS, some reloading Q with word one
    auto_exp = 1'b1;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 11);
      ld  = ($urandom_range(0, 2) == 0);
      qv  = $urandom_range(0, 31);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_word($urandom_range(0, 31), $urandom_range(0, 3),
                  (i == len - 1), ld && (i == 0), qv);
      end
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
